sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 94 +++++++++
 tb/tb_sw_debounce.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
`default_nettype none
// sw_debounce -- two-flop synchronizer plus per-bit tick-sampled agreement counters for WIDTH switches.
// Rev 1.0
module sw_debounce #(
  parameter int WIDTH        = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_COUNT = 4
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_changed,
  output logic [7:0]       x,
  output logic [7:0]       y,
  output logic             s
);

  localparam int              C_TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [C_TW-1:0] C_TICK_LAST = C_TW'(TICK_DIV - 1);
  localparam logic [3:0]      C_CNT_LAST  = 4'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [C_TW-1:0]  tick_cnt_q;
  logic [C_TW-1:0]  tick_cnt_d;
  logic             tick;
  logic [3:0]       cnt_q [WIDTH];
  logic [3:0]       cnt_d [WIDTH];
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic             changed_q;

  // With TICK_DIV=1 the counter is a constant 0 and tick fires every cycle.
  assign tick       = (tick_cnt_q == C_TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == clean_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == C_CNT_LAST) begin
          clean_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      clean_q    <= '0;
      changed_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= SW;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      clean_q    <= clean_d;
      changed_q  <= |(clean_d ^ clean_q);
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_clean   = clean_q;
  assign sw_changed = changed_q;

  // The mux-stage taps only exist on the full 18-switch board layout.
  generate
    if (WIDTH >= 18) begin : g_xys
      assign x = clean_q[7:0];
      assign y = clean_q[15:8];
      assign s = clean_q[17];
    end else begin : g_no_xys
      assign x = '0;
      assign y = '0;
      assign s = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// tb_sw_debounce -- vector table, corner sequences and randomized bounces against a tick-history model.
// Rev 1.0
module tb_sw_debounce;

  localparam int WIDTH = 18;
  localparam int TD    = 4;
  localparam int SC    = 3;

  logic             clk    = 1'b0;
  logic             resetn = 1'b0;
  logic [WIDTH-1:0] SW     = '0;
  logic [WIDTH-1:0] sw_clean;
  logic             sw_changed;
  logic [7:0]       x;
  logic [7:0]       y;
  logic             s;

  always #5 clk = ~clk;

  sw_debounce #(.WIDTH(WIDTH), .TICK_DIV(TD), .STABLE_COUNT(SC)) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .SW        (SW),
    .sw_clean  (sw_clean),
    .sw_changed(sw_changed),
    .x         (x),
    .y         (y),
    .s         (s)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: SW seen two edges late, sampled every TD-th edge after release; a bit
  // flips once its last SC tick samples, all taken since its previous flip, disagree.
  logic [WIDTH-1:0] exp_clean;
  logic             exp_changed;
  logic [WIDTH-1:0] sw_hist[$];
  logic [WIDTH-1:0] tick_samp[$];
  int               since[WIDTH];
  int               edge_n;
  int               pulse_cnt;

  typedef struct {
    logic [WIDTH-1:0] sw;
    int               hold;
    logic [WIDTH-1:0] clean;
    int               pulses;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    exp_clean   = '0;
    exp_changed = 1'b0;
    sw_hist.delete();
    sw_hist.push_back('0);
    sw_hist.push_back('0);
    tick_samp.delete();
    for (int i = 0; i < WIDTH; i++) since[i] = 0;
    edge_n = 0;
  endtask

  task automatic model_edge();
    logic [WIDTH-1:0] smp;
    bit               all_dis;
    exp_changed = 1'b0;
    if (!resetn) begin
      model_clear();
    end else begin
      sw_hist.push_back(SW);
      smp = sw_hist[sw_hist.size() - 3];
      if (sw_hist.size() > 3) void'(sw_hist.pop_front());
      edge_n++;
      if (edge_n % TD == 0) begin
        tick_samp.push_back(smp);
        if (tick_samp.size() > SC) void'(tick_samp.pop_front());
        for (int i = 0; i < WIDTH; i++) begin
          since[i]++;
          if (since[i] >= SC) begin
            all_dis = 1'b1;
            for (int j = 0; j < SC; j++)
              if (tick_samp[j][i] == exp_clean[i]) all_dis = 1'b0;
            if (all_dis) begin
              exp_clean[i] = ~exp_clean[i];
              since[i]     = 0;
              exp_changed  = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("clean", 32'(sw_clean), 32'(exp_clean));
    check("changed", 32'(sw_changed), 32'(exp_changed));
    check("xys", 32'({s, y, x}), 32'({exp_clean[17], exp_clean[15:8], exp_clean[7:0]}));
    if (sw_changed) pulse_cnt++;
  endtask

  task automatic latency(input string name, input int bitn);
    int n;
    n = 0;
    while (sw_clean[bitn] !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (n < 11 || n > 14) begin
      n_fail++;
      $display("FAIL %s: rose after %0d edges, required 11..14", name, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] lvl, fin, mask, prev, flipped, twice;

    vecs[0] = '{18'h00000, 50, 18'h00000, 0};
    vecs[1] = '{18'h2A55C, 20, 18'h2A55C, 1};
    vecs[2] = '{18'h3FFFF, 20, 18'h3FFFF, 1};
    vecs[3] = '{18'h00000, 20, 18'h00000, 1};
    vecs[4] = '{18'h00008,  3, 18'h00000, 0};
    vecs[5] = '{18'h00000, 20, 18'h00000, 0};
    vecs[6] = '{18'h00001, 20, 18'h00001, 1};
    vecs[7] = '{18'h00000, 20, 18'h00000, 1};

    model_clear();
    pulse_cnt = 0;
    repeat (3) cycle();
    check("reset_clean", 32'(sw_clean), 32'h0);
    check("reset_changed", 32'(sw_changed), 32'h0);
    resetn = 1'b1;

    foreach (vecs[k]) begin
      SW        = vecs[k].sw;
      pulse_cnt = 0;
      repeat (vecs[k].hold) cycle();
      check("vec_clean", 32'(sw_clean), 32'(vecs[k].clean));
      check("vec_pulses", 32'(pulse_cnt), 32'(vecs[k].pulses));
      check("vec_x", 32'(x), 32'(vecs[k].clean[7:0]));
      check("vec_y", 32'(y), 32'(vecs[k].clean[15:8]));
      check("vec_s", 32'(s), 32'(vecs[k].clean[17]));
    end

    // Single step on bit 0: latency window and exactly one pulse.
    SW        = 18'h00001;
    pulse_cnt = 0;
    latency("step_latency", 0);
    repeat (10) cycle();
    check("step_pulses", 32'(pulse_cnt), 32'd1);

    // 6-cycle glitches on bit 3 never reach the output.
    pulse_cnt = 0;
    repeat (5) begin
      SW[3] = 1'b1;
      repeat (6) cycle();
      SW[3] = 1'b0;
      repeat (6) cycle();
    end
    repeat (20) cycle();
    check("glitch_bit3", 32'(sw_clean[3]), 32'h0);
    check("glitch_pulses", 32'(pulse_cnt), 32'd0);

    // Reset in the middle of a bit-17 debounce clears everything asynchronously.
    SW = 18'h20001;
    repeat (7) cycle();
    resetn = 1'b0;
    model_clear();
    #1;
    check("async_rst_clean", 32'(sw_clean), 32'h0);
    check("async_rst_changed", 32'(sw_changed), 32'h0);
    repeat (3) cycle();
    resetn    = 1'b1;
    pulse_cnt = 0;
    latency("post_reset_latency", 17);
    repeat (10) cycle();
    check("post_reset_clean", 32'(sw_clean), 32'h20001);
    check("post_reset_pulses", 32'(pulse_cnt), 32'd1);

    // Random bounces around the settled level, then a random stable level.
    lvl = SW;
    repeat (12) begin
      mask = WIDTH'($urandom);
      repeat ($urandom_range(2, 6)) begin
        SW = lvl ^ mask;
        repeat ($urandom_range(1, 8)) cycle();
        SW = lvl;
        repeat ($urandom_range(1, 8)) cycle();
      end
      fin     = WIDTH'($urandom);
      SW      = fin;
      prev    = sw_clean;
      flipped = '0;
      twice   = '0;
      repeat (20) begin
        cycle();
        twice   = twice | ((prev ^ sw_clean) & flipped);
        flipped = flipped | (prev ^ sw_clean);
        prev    = sw_clean;
      end
      check("rand_final", 32'(sw_clean), 32'(fin));
      check("rand_once", 32'(twice), 32'h0);
      lvl = fin;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
